afu_write_ctrl: RTL and testbench
=================================

AFU_WRITE_CTRL -- requirements
Module: afu_write_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, meaning max unacknowledged write requests (power of two, 2..64).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning width of line counters and addresses.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, meaning one-cycle pulse to begin a context.
REQ-006 SHALL have port ctx_length, input, CNT_WIDTH, meaning number of 512-bit lines to write; sampled on start.
REQ-007 SHALL have port ctx_dst_addr, input, CNT_WIDTH, meaning destination cache-line address of line 0; sampled on start.
REQ-008 SHALL have port fifo_dout, input, 512, meaning transposed data from the upstream output FIFO.
REQ-009 SHALL have port fifo_empty, input, 1, meaning upstream FIFO empty.
REQ-010 SHALL have port fifo_re, output, 1, meaning FIFO read strobe; data valid on fifo_dout the following cycle.
REQ-011 SHALL have port wr_valid, output, 1, meaning write request valid.
REQ-012 SHALL have port wr_ready, input, 1, meaning write channel accepts the request this cycle.
REQ-013 SHALL have port wr_addr, output, CNT_WIDTH, meaning cache-line address of the request.
REQ-014 SHALL have port wr_data, output, 512, meaning request payload.
REQ-015 SHALL have port wr_rsp_valid, input, 1, meaning one write completion this cycle.
REQ-016 SHALL have port busy, output, 1, meaning context in progress.
REQ-017 SHALL have port done, output, 1, meaning context complete; held until next start.
REQ-018 SHALL have port rsp_error, output, 1, meaning sticky flag: completion received with zero outstanding.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-020 SHALL move IDLE/DONE -> RUN on start, latching ctx_length and ctx_dst_addr, clearing issue/completion counters and done.
REQ-021 SHALL, when start has ctx_length == 0, go directly to DONE (done=1 next cycle, no fifo_re, no wr_valid).
REQ-022 SHALL ignore start in RUN or DRAIN.
REQ-023 SHALL hold a one-entry output register (wr_valid/wr_addr/wr_data) plus one in-flight FIFO read flag.
REQ-024 SHALL assert fifo_re in RUN only when: !fifo_empty, lines read < ctx_length, no read in flight or register will be free, and (outstanding + register occupancy + in-flight) < MAX_OUTSTANDING.
REQ-025 SHALL load fifo_dout into wr_data exactly one cycle after fifo_re, with wr_addr = ctx_dst_addr + lines issued so far, wrapping modulo 2^CNT_WIDTH.
REQ-026 SHALL keep wr_valid, wr_addr, wr_data stable while wr_valid && !wr_ready.
REQ-027 SHALL, on wr_valid && wr_ready, increment issued count and outstanding; a new line may be loaded the same cycle (back-to-back, 1 line/cycle sustained).
REQ-028 SHALL decrement outstanding on wr_rsp_valid; simultaneous issue and response leave outstanding unchanged.
REQ-029 SHALL, on wr_rsp_valid with outstanding == 0 and no simultaneous issue, set rsp_error and leave outstanding at 0.
REQ-030 SHALL move RUN -> DRAIN when issued count == ctx_length; DRAIN -> DONE when completions == ctx_length.
REQ-031 SHALL assert busy in RUN and DRAIN only; done only in DONE.
REQ-032 SHALL never read more than ctx_length lines from the FIFO per context.

Reset
REQ-033 SHALL, while reset is low, force state IDLE, all counters 0, fifo_re=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, rsp_error=0, asynchronously.
REQ-034 SHALL, on reset mid-context, abandon the context; leftover FIFO data is not drained.
REQ-035 SHALL clear rsp_error only by reset.

Verification
REQ-036 start, length=4, addr=0x100, FIFO pre-filled, wr_ready=1, immediate responses -> addrs 0x100..0x103 on consecutive cycles, data in FIFO order, done=1 after 4th response.
REQ-037 length=0 start -> done=1 next cycle, no fifo_re, no wr_valid.
REQ-038 length=20, MAX_OUTSTANDING=8, no responses -> exactly 8 accepted writes, wr_valid then stalls; one response -> exactly one more write.
REQ-039 wr_ready toggled randomly -> wr_addr/wr_data stable while stalled, no line lost or duplicated, fifo_re count == 20.
REQ-040 addr=0xFFFFFFFE, length=3 -> addrs 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-041 wr_rsp_valid in IDLE -> rsp_error=1 sticky; reset low mid-RUN -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/afu_write_ctrl_if.sv
// Write-controller bus bundle: upstream FIFO read port plus the write request/completion channel.
// The master modport is the controller side, the slave modport is the FIFO/memory side.
interface afu_write_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic [511:0]         fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_re;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [CNT_WIDTH-1:0] wr_addr;
  logic [511:0]         wr_data;
  logic                 wr_rsp_valid;

  modport master (
    input  fifo_dout, fifo_empty, wr_ready, wr_rsp_valid,
    output fifo_re, wr_valid, wr_addr, wr_data
  );

  modport slave (
    output fifo_dout, fifo_empty, wr_ready, wr_rsp_valid,
    input  fifo_re, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/afu_write_ctrl.sv
// Streams ctx_length lines from the upstream FIFO into write requests at consecutive line
// addresses, bounding unacknowledged writes to MAX_OUTSTANDING.
module afu_write_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] ctx_length,
  input  logic [CNT_WIDTH-1:0] ctx_dst_addr,
  afu_write_ctrl_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic                 rsp_error
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned OccW = OutW + 1;
  localparam logic [OccW-1:0]      MaxOcc = OccW'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] One    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] len_q, base_q, rd_cnt_q, iss_cnt_q, cmp_cnt_q;
  logic [OutW-1:0]      outst_q;
  logic                 inflight_q, wr_valid_q;
  logic [CNT_WIDTH-1:0] wr_addr_q;
  logic [511:0]         wr_data_q;
  logic                 busy_q, done_q, rsp_error_q;

  logic            fire, reg_free, load, rsp_ok, fifo_re;
  logic [OccW-1:0] occ;

  // The FIFO is assumed to hold fifo_dout until the next fifo_re, so an in-flight line
  // simply waits while the output register is stalled.
  always_comb begin
    fire     = wr_valid_q & bus.wr_ready;
    reg_free = ~wr_valid_q | bus.wr_ready;
    load     = inflight_q & reg_free;
    rsp_ok   = bus.wr_rsp_valid & (fire | (outst_q != '0));
    occ      = OccW'(outst_q) + OccW'(wr_valid_q) + OccW'(inflight_q);
    fifo_re  = (state_q == StRun) & ~bus.fifo_empty & (rd_cnt_q < len_q) &
               (~inflight_q | reg_free) & (occ < MaxOcc);
  end

  assign bus.fifo_re  = fifo_re;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign rsp_error    = rsp_error_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      base_q      <= '0;
      rd_cnt_q    <= '0;
      iss_cnt_q   <= '0;
      cmp_cnt_q   <= '0;
      outst_q     <= '0;
      inflight_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      if (fifo_re) rd_cnt_q <= rd_cnt_q + One;
      inflight_q <= fifo_re | (inflight_q & ~load);

      // A firing register is refilled in the same cycle, so its line counts as issued.
      if (load) begin
        wr_valid_q <= 1'b1;
        wr_addr_q  <= base_q + iss_cnt_q + CNT_WIDTH'(fire);
        wr_data_q  <= bus.fifo_dout;
      end else if (fire) begin
        wr_valid_q <= 1'b0;
      end

      if (fire)   iss_cnt_q <= iss_cnt_q + One;
      if (rsp_ok) cmp_cnt_q <= cmp_cnt_q + One;

      if (fire & ~bus.wr_rsp_valid)  outst_q <= outst_q + OutW'(1);
      else if (~fire & rsp_ok)       outst_q <= outst_q - OutW'(1);
      if (bus.wr_rsp_valid & ~rsp_ok) rsp_error_q <= 1'b1;

      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            len_q     <= ctx_length;
            base_q    <= ctx_dst_addr;
            rd_cnt_q  <= '0;
            iss_cnt_q <= '0;
            cmp_cnt_q <= '0;
            if (ctx_length == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        StRun: begin
          if (iss_cnt_q == len_q) state_q <= StDrain;
        end
        StDrain: begin
          if (cmp_cnt_q == len_q) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_afu_write_ctrl.sv
// Scoreboard bench for afu_write_ctrl: stimulus queues expected writes, a negedge monitor
// pops and compares every accepted write and checks stall stability.
module tb_afu_write_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ctx_length = '0;
  logic [31:0] ctx_dst_addr = '0;
  logic        busy, done, rsp_error;

  afu_write_ctrl_if #(.CNT_WIDTH(32)) bus ();

  afu_write_ctrl #(.MAX_OUTSTANDING(8), .CNT_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ctx_length   (ctx_length),
    .ctx_dst_addr (ctx_dst_addr),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .rsp_error    (rsp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
  } wr_t;

  wr_t          sb[$];
  logic [511:0] mem[256];
  int           wr_ptr = 0, rd_ptr = 0, re_cnt = 0;
  int           acc_cnt = 0, cyc = 0;
  int           acc_cyc[256];
  int           errors = 0, checks = 0;
  logic         rdy_fixed = 1'b0, rdy_rand = 1'b0, rnd_q = 1'b0;
  logic         rsp_auto = 1'b0, rsp_auto_q = 1'b0, rsp_manual = 1'b0;
  logic         prev_stall = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [511:0] prev_data = '0;
  wr_t          mon_e;

  assign bus.fifo_empty   = (wr_ptr == rd_ptr);
  assign bus.wr_ready     = rdy_rand ? rnd_q : rdy_fixed;
  assign bus.wr_rsp_valid = rsp_auto_q | rsp_manual;

  // FIFO model (dout held until next read), random ready source, immediate responder.
  initial begin
    bus.fifo_dout = '0;
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (bus.fifo_re) begin
        bus.fifo_dout <= mem[rd_ptr % 256];
        rd_ptr        <= rd_ptr + 1;
        re_cnt        <= re_cnt + 1;
      end
      rnd_q      <= 1'($urandom_range(0, 1));
      rsp_auto_q <= rsp_auto && bus.wr_valid && bus.wr_ready && reset;
    end
  end

  // Monitor: compare each accepted write against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!bus.wr_valid || bus.wr_addr !== prev_addr || bus.wr_data !== prev_data) begin
            errors++;
            $display("FAIL stall_hold: valid=%0b addr=%h, required valid=1 addr=%h data unchanged",
                     bus.wr_valid, bus.wr_addr, prev_addr);
          end
        end
        if (bus.wr_valid && bus.wr_ready) begin
          acc_cyc[acc_cnt % 256] = cyc;
          acc_cnt++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h, required no write", bus.wr_addr);
          end else begin
            mon_e = sb.pop_front();
            if (bus.wr_addr !== mon_e.addr || bus.wr_data !== mon_e.data) begin
              errors++;
              $display("FAIL write_%0d: addr=%h data[31:0]=%h, required addr=%h data[31:0]=%h",
                       acc_cnt, bus.wr_addr, bus.wr_data[31:0], mon_e.addr, mon_e.data[31:0]);
            end
          end
        end
        prev_stall = bus.wr_valid && !bus.wr_ready;
        prev_addr  = bus.wr_addr;
        prev_data  = bus.wr_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] line_data(input int t, input int k);
    logic [511:0] d;
    logic [31:0]  w;
    w = 32'hC0DE_0000 + 32'(t * 256 + k);
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = w + 32'(i) * 32'h0100_0000;
    return d;
  endfunction

  task automatic push_line(input logic [31:0] addr, input logic [511:0] data, input bit exp_wr);
    wr_t e;
    mem[wr_ptr % 256] = data;
    wr_ptr++;
    if (exp_wr) begin
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
    end
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic do_start(input logic [31:0] len, input logic [31:0] addr);
    ctx_length   = len;
    ctx_dst_addr = addr;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lim);
    int i = 0;
    while (!done && i < lim) begin
      tick();
      i++;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  int r0, a0;

  initial begin
    #2 reset = 1'b0;
    tick();
    chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("rst_fifo_re", 64'(bus.fifo_re), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(|bus.wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    reset = 1'b1;
    tick();

    // Basic 4-line context, back-to-back with immediate responses.
    rdy_fixed = 1'b1;
    rsp_auto  = 1'b1;
    for (int k = 0; k < 4; k++) push_line(32'h100 + 32'(k), line_data(1, k), 1'b1);
    r0 = re_cnt;
    a0 = acc_cnt;
    do_start(32'd4, 32'h100);
    chk("t1_busy_run", 64'(busy), 64'd1);
    wait_done("t1_done", 50);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_reads", 64'(re_cnt - r0), 64'd4);
    chk("t1_writes", 64'(acc_cnt - a0), 64'd4);
    chk("t1_b2b", 64'(acc_cyc[(a0 + 3) % 256] - acc_cyc[a0 % 256]), 64'd3);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Zero-length context from IDLE.
    do_reset();
    for (int k = 0; k < 2; k++) push_line(32'h0, line_data(2, k), 1'b0);
    r0 = re_cnt;
    a0 = acc_cnt;
    do_start(32'd0, 32'h200);
    chk("t2_done_next", 64'(done), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("t2_reads", 64'(re_cnt - r0), 64'd0);
    chk("t2_writes", 64'(acc_cnt - a0), 64'd0);
    chk("t2_wr_valid", 64'(bus.wr_valid), 64'd0);
    flush();

    // Outstanding limit: 8 writes with no responses, then one response frees one slot.
    rsp_auto = 1'b0;
    for (int k = 0; k < 20; k++)
      push_line(32'h1000 + 32'(k), line_data(3, k), (k < 9) ? 1'b1 : 1'b0);
    r0 = re_cnt;
    a0 = acc_cnt;
    do_start(32'd20, 32'h1000);
    repeat (30) tick();
    chk("t3_writes_8", 64'(acc_cnt - a0), 64'd8);
    chk("t3_reads_8", 64'(re_cnt - r0), 64'd8);
    chk("t3_stalled", 64'(bus.wr_valid), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    rsp_manual = 1'b1;
    tick();
    rsp_manual = 1'b0;
    repeat (20) tick();
    chk("t3_writes_9", 64'(acc_cnt - a0), 64'd9);
    chk("t3_reads_9", 64'(re_cnt - r0), 64'd9);
    chk("t3_rsp_error", 64'(rsp_error), 64'd0);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);
    do_reset();
    flush();

    // Random backpressure over 20 lines.
    rsp_auto = 1'b1;
    rdy_rand = 1'b1;
    for (int k = 0; k < 20; k++) push_line(32'h2000 + 32'(k), line_data(4, k), 1'b1);
    r0 = re_cnt;
    a0 = acc_cnt;
    do_start(32'd20, 32'h2000);
    wait_done("t4_done", 2000);
    rdy_rand = 1'b0;
    chk("t4_reads", 64'(re_cnt - r0), 64'd20);
    chk("t4_writes", 64'(acc_cnt - a0), 64'd20);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    chk("t4_rsp_error", 64'(rsp_error), 64'd0);

    // Address wrap at the top of the address space.
    push_line(32'hFFFF_FFFE, line_data(5, 0), 1'b1);
    push_line(32'hFFFF_FFFF, line_data(5, 1), 1'b1);
    push_line(32'h0000_0000, line_data(5, 2), 1'b1);
    a0 = acc_cnt;
    do_start(32'd3, 32'hFFFF_FFFE);
    wait_done("t5_done", 50);
    chk("t5_writes", 64'(acc_cnt - a0), 64'd3);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Spurious response in IDLE, then asynchronous reset in the middle of a stalled context.
    rsp_auto = 1'b0;
    do_reset();
    rsp_manual = 1'b1;
    tick();
    rsp_manual = 1'b0;
    tick();
    chk("t6_rsp_error", 64'(rsp_error), 64'd1);
    repeat (3) tick();
    chk("t6_rsp_sticky", 64'(rsp_error), 64'd1);
    chk("t6_idle_done", 64'(done), 64'd0);
    chk("t6_idle_busy", 64'(busy), 64'd0);
    rdy_fixed = 1'b0;
    for (int k = 0; k < 10; k++) push_line(32'h3000 + 32'(k), line_data(6, k), 1'b0);
    do_start(32'd10, 32'h3000);
    repeat (5) tick();
    chk("t6_run_busy", 64'(busy), 64'd1);
    chk("t6_run_valid", 64'(bus.wr_valid), 64'd1);
    reset = 1'b0;
    #2;
    chk("t6_arst_wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("t6_arst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("t6_arst_wr_data", 64'(|bus.wr_data), 64'd0);
    chk("t6_arst_fifo_re", 64'(bus.fifo_re), 64'd0);
    chk("t6_arst_busy", 64'(busy), 64'd0);
    chk("t6_arst_done", 64'(done), 64'd0);
    chk("t6_arst_rsp_error", 64'(rsp_error), 64'd0);
    tick();
    reset = 1'b1;
    r0 = re_cnt;
    repeat (3) tick();
    chk("t6_idle_no_read", 64'(re_cnt - r0), 64'd0);
    chk("t6_idle_busy_after", 64'(busy), 64'd0);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
